// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) with a start/busy/done handshake.
// Writes HI/LO and strobes zero/sign/ovf into the flags register on completion.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             flags_write,
   output logic             zero,
   output logic             sign,
   output logic             ovf,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   p_hi_q, p_hi_d;
   logic [WIDTH-1:0]   p_lo_q, p_lo_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic               sovf_q, sovf_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               zero_q, zero_d;
   logic               sign_q, sign_d;
   logic               ovf_q, ovf_d;
   logic               dbz_q, dbz_d;

   logic               sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Next-state and datapath
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      mcand_d   = mcand_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      sovf_d    = sovf_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      zero_d    = zero_q;
      sign_d    = sign_q;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      sgn_op = ~op[0];
      a_neg  = sgn_op & a[WIDTH-1];
      b_neg  = sgn_op & b[WIDTH-1];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;

      add_sum  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
      rem_sh   = {p_hi_q, p_lo_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, mcand_q};

      prod     = {p_hi_q, p_lo_q};
      prod_fix = neg_quo_q ? -prod : prod;
      quo_fix  = dz_q ? '1 : (neg_quo_q ? -p_lo_q : p_lo_q);
      rem_fix  = neg_rem_q ? -p_hi_q : p_hi_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               op_d      = op;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dz_d      = op[1] & (b == '0);
               sovf_d    = (op == 2'b10) & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
               p_hi_d    = '0;
               p_lo_d    = op[1] ? a_mag : b_mag;
               mcand_d   = op[1] ? b_mag : a_mag;
               cnt_d     = CNT_W'(WIDTH);
               busy_d    = 1'b1;
               state_d   = CALC;
            end
         end
         CALC: begin
            busy_d = 1'b1;
            // One extra settle cycle after the last bit keeps latency fixed at WIDTH+2
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (op_q[1]) begin
                  if (!rem_diff[WIDTH]) begin
                     p_hi_d = rem_diff[WIDTH-1:0];
                     p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
                  end else begin
                     p_hi_d = rem_sh[WIDTH-1:0];
                     p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  p_hi_d = add_sum[WIDTH:1];
                  p_lo_d = {add_sum[0], p_lo_q[WIDTH-1:1]};
               end
            end
         end
         FIX: begin
            state_d = DONE;
            done_d  = 1'b1;
            if (op_q[1]) begin
               hi_d   = rem_fix;
               lo_d   = quo_fix;
               zero_d = (quo_fix == '0);
               sign_d = quo_fix[WIDTH-1];
               ovf_d  = dz_q | sovf_q;
               dbz_d  = dz_q;
            end else begin
               hi_d   = prod_fix[2*WIDTH-1:WIDTH];
               lo_d   = prod_fix[WIDTH-1:0];
               zero_d = (prod_fix == '0);
               sign_d = prod_fix[2*WIDTH-1];
               ovf_d  = op_q[0] ? (prod_fix[2*WIDTH-1:WIDTH] != '0)
                                : (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
               dbz_d  = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         p_hi_q    <= '0;
         p_lo_q    <= '0;
         mcand_q   <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         sovf_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         zero_q    <= 1'b0;
         sign_q    <= 1'b0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         mcand_q   <= mcand_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         sovf_q    <= sovf_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         zero_q    <= zero_d;
         sign_q    <= sign_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign flags_write = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign zero        = zero_q;
   assign sign        = sign_q;
   assign ovf         = ovf_q;
   assign div_by_zero = dbz_q;

endmodule
